// File: rtl/except_commit_pkg.sv
// rtl/except_commit_pkg.sv - exception codes, raw flag positions, CP0 addresses, priority select
package except_commit_pkg;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BRK  = 32'h9;
  localparam logic [31:0] EXC_INV  = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TRAP = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam int FLAG_SYS  = 0;
  localparam int FLAG_INV  = 1;
  localparam int FLAG_TRAP = 2;
  localparam int FLAG_OV   = 3;
  localparam int FLAG_ERET = 4;
  localparam int FLAG_BRK  = 5;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // flags is excepttype[13:8]; the first match in this chain wins
  function automatic logic [31:0] select_exc(input logic int_pend, input logic [5:0] flags);
    if (int_pend)             return EXC_INT;
    else if (flags[FLAG_SYS])  return EXC_SYS;
    else if (flags[FLAG_INV])  return EXC_INV;
    else if (flags[FLAG_TRAP]) return EXC_TRAP;
    else if (flags[FLAG_OV])   return EXC_OV;
    else if (flags[FLAG_BRK])  return EXC_BRK;
    else if (flags[FLAG_ERET]) return EXC_ERET;
    else                       return EXC_NONE;
  endfunction

endpackage

// File: rtl/except_commit_cp0_fwd.sv
// rtl/except_commit_cp0_fwd.sv - combinational WB->CP0 forwarding of Status/Cause/EPC
module cp0_fwd
  import except_commit_pkg::*;
(
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] status_f,
  output logic [31:0] cause_f,
  output logic [31:0] epc_f
);

  always_comb begin
    status_f = cp0_status_i;
    cause_f  = cp0_cause_i;
    epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_STATUS: status_f = wb_cp0_data_i;
        CP0_EPC:    epc_f    = wb_cp0_data_i;
        // only the software-writable Cause fields are taken from the WB write
        CP0_CAUSE: begin
          cause_f[9:8] = wb_cp0_data_i[9:8];
          cause_f[23]  = wb_cp0_data_i[23];
          cause_f[22]  = wb_cp0_data_i[22];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/except_commit.sv
// rtl/except_commit.sv - MEM-stage exception select, registered CP0 commit and pipeline flush
module except_commit
  import except_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        mem_kill_o
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] exc_d, addr_d, newpc_d;
  logic        ds_d, flush_d;
  logic [31:0] status_f, cause_f, epc_f;
  logic        int_pend;
  logic [31:0] sel_code;
  logic        unused_bits;

  cp0_fwd u_cp0_fwd (
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .status_f       (status_f),
    .cause_f        (cause_f),
    .epc_f          (epc_f)
  );

  assign unused_bits = ^{excepttype_i[31:14], excepttype_i[7:0], status_f[31:16],
                         status_f[7:2], cause_f[31:16], cause_f[7:0]};

  assign int_pend = (|(cause_f[15:8] & status_f[15:8])) && !status_f[1] && status_f[0];
  assign sel_code = select_exc(int_pend, excepttype_i[13:8]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exc_d      = EXC_NONE;
    addr_d     = current_inst_addr_o;
    ds_d       = is_in_delayslot_o;
    flush_d    = 1'b0;
    newpc_d    = 32'h0;
    mem_kill_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid_i && sel_code != EXC_NONE) begin
          mem_kill_o = 1'b1;
          exc_d      = sel_code;
          addr_d     = current_inst_addr_i;
          ds_d       = is_in_delayslot_i;
          flush_d    = 1'b1;
          newpc_d    = (sel_code == EXC_ERET) ? epc_f : EXC_VECTOR;
          cnt_d      = 2'(FLUSH_CYCLES - 1);
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // younger instructions are squashed until the flush window closes
        mem_kill_o = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - 2'd1;
          flush_d = 1'b1;
          newpc_d = new_pc_o;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      cnt_q               <= 2'd0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'h0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      excepttype_o        <= exc_d;
      current_inst_addr_o <= addr_d;
      is_in_delayslot_o   <= ds_d;
      flush_o             <= flush_d;
      new_pc_o            <= newpc_d;
    end
  end

endmodule

// File: tb/tb_except_commit.sv
// tb/tb_except_commit.sv - directed bench for except_commit with FLUSH_CYCLES 1 and 3
module tb_except_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] exc_in, pc_in, status, cause, epc, wb_data;
  logic        ds_in, wb_we;
  logic [4:0]  wb_addr;

  logic [31:0] e1, a1, p1, e3, a3, p3;
  logic        d1, f1, k1, d3, f3, k3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  except_commit #(.FLUSH_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .excepttype_i(exc_in),
    .current_inst_addr_i(pc_in), .is_in_delayslot_i(ds_in), .cp0_status_i(status),
    .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr),
    .wb_cp0_data_i(wb_data), .excepttype_o(e1), .current_inst_addr_o(a1),
    .is_in_delayslot_o(d1), .flush_o(f1), .new_pc_o(p1), .mem_kill_o(k1)
  );

  except_commit #(.FLUSH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .excepttype_i(exc_in),
    .current_inst_addr_i(pc_in), .is_in_delayslot_i(ds_in), .cp0_status_i(status),
    .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr),
    .wb_cp0_data_i(wb_data), .excepttype_o(e3), .current_inst_addr_o(a3),
    .is_in_delayslot_o(d3), .flush_o(f3), .new_pc_o(p3), .mem_kill_o(k3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_valid = 0; exc_in = 0; pc_in = 0; ds_in = 0;
    status = 0; cause = 0; epc = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic drain();
    set_idle();
    repeat (5) cyc();
  endtask

  task automatic test_reset();
    rst = 1;
    set_idle();
    repeat (3) cyc();
    checks++; if ({e1, a1, p1, d1, f1, k1} !== '0) begin errors++; $display("FAIL reset_u1 got e=%h a=%h p=%h d=%b f=%b k=%b exp all 0", e1, a1, p1, d1, f1, k1); end
    checks++; if ({e3, a3, p3, d3, f3, k3} !== '0) begin errors++; $display("FAIL reset_u3 got e=%h a=%h p=%h d=%b f=%b k=%b exp all 0", e3, a3, p3, d3, f3, k3); end
    rst = 0;
    cyc();
  endtask

  task automatic test_syscall();
    drain();
    mem_valid = 1; exc_in = 32'h100; pc_in = 32'h40; status = 32'h1000_0000;
    #1;
    checks++; if (k1 !== 1'b1) begin errors++; $display("FAIL sys_kill got %b exp 1", k1); end
    cyc();
    mem_valid = 0; exc_in = 0;
    checks++; if (e1 !== 32'h8) begin errors++; $display("FAIL sys_code got %h exp 8", e1); end
    checks++; if (a1 !== 32'h40 || d1 !== 1'b0) begin errors++; $display("FAIL sys_pc got %h/%b exp 40/0", a1, d1); end
    checks++; if (f1 !== 1'b1 || p1 !== 32'h20) begin errors++; $display("FAIL sys_flush got %b/%h exp 1/20", f1, p1); end
    cyc();
    checks++; if (e1 !== 32'h0 || f1 !== 1'b0) begin errors++; $display("FAIL sys_after got %h/%b exp 0/0", e1, f1); end
  endtask

  task automatic test_eret_fwd();
    drain();
    mem_valid = 1; exc_in = 32'h1000; pc_in = 32'h80; ds_in = 1; epc = 32'h5555;
    wb_we = 1; wb_addr = 5'd14; wb_data = 32'h1234;
    cyc();
    checks++; if (e1 !== 32'he || p1 !== 32'h1234) begin errors++; $display("FAIL eret got %h/%h exp e/1234", e1, p1); end
    checks++; if (d1 !== 1'b1 || a1 !== 32'h80) begin errors++; $display("FAIL eret_ds got %b/%h exp 1/80", d1, a1); end
  endtask

  task automatic test_int_priority();
    drain();
    mem_valid = 1; exc_in = 32'h800; cause = 32'h400; status = 32'h401;
    #1;
    checks++; if (k1 !== 1'b1) begin errors++; $display("FAIL int_kill got %b exp 1", k1); end
    cyc();
    checks++; if (e1 !== 32'h1 || p1 !== 32'h20) begin errors++; $display("FAIL int_code got %h/%h exp 1/20", e1, p1); end
  endtask

  task automatic test_int_masked();
    drain();
    mem_valid = 1; exc_in = 0; cause = 32'h400; status = 32'h403;
    #1;
    checks++; if (k1 !== 1'b0) begin errors++; $display("FAIL mask_kill got %b exp 0", k1); end
    cyc();
    checks++; if (e1 !== 32'h0 || f1 !== 1'b0 || p1 !== 32'h0) begin errors++; $display("FAIL mask_out got %h/%b/%h exp 0/0/0", e1, f1, p1); end
    exc_in = 32'h800;
    cyc();
    checks++; if (e1 !== 32'hc) begin errors++; $display("FAIL mask_ov got %h exp c", e1); end
  endtask

  task automatic test_fwd_regs();
    drain();
    mem_valid = 1; status = 32'h101; wb_we = 1; wb_addr = 5'd13; wb_data = 32'h100;
    cyc();
    checks++; if (e1 !== 32'h1) begin errors++; $display("FAIL cause_fwd got %h exp 1", e1); end
    drain();
    mem_valid = 1; status = 32'h401; wb_we = 1; wb_addr = 5'd13; wb_data = 32'h400;
    #1;
    checks++; if (k1 !== 1'b0) begin errors++; $display("FAIL cause_mask got %b exp 0", k1); end
    drain();
    mem_valid = 1; cause = 32'h400; status = 32'h0; wb_we = 1; wb_addr = 5'd12; wb_data = 32'h401;
    cyc();
    checks++; if (e1 !== 32'h1) begin errors++; $display("FAIL status_fwd got %h exp 1", e1); end
  endtask

  task automatic test_multi_flag();
    logic [31:0] vin [3];
    logic [31:0] vexp [3];
    vin = '{32'h3E00, 32'h2C00, 32'h3000};
    vexp = '{32'ha, 32'hd, 32'h9};
    for (int i = 0; i < 3; i++) begin
      drain();
      mem_valid = 1; exc_in = vin[i];
      cyc();
      checks++; if (e1 !== vexp[i]) begin errors++; $display("FAIL multi_%0d got %h exp %h", i, e1, vexp[i]); end
    end
    drain();
    exc_in = 32'h100;
    #1;
    checks++; if (k1 !== 1'b0) begin errors++; $display("FAIL bubble_kill got %b exp 0", k1); end
    cyc();
    checks++; if (f1 !== 1'b0 || e1 !== 32'h0) begin errors++; $display("FAIL bubble_out got %b/%h exp 0/0", f1, e1); end
  endtask

  task automatic test_back_to_back();
    drain();
    mem_valid = 1; exc_in = 32'h100; pc_in = 32'h300;
    cyc();
    checks++; if (e1 !== 32'h8 || f1 !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 8/1", e1, f1); end
    cyc();
    checks++; if (e1 !== 32'h0 || f1 !== 1'b0) begin errors++; $display("FAIL b2b_gap got %h/%b exp 0/0", e1, f1); end
    cyc();
    checks++; if (e1 !== 32'h8 || f1 !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp 8/1", e1, f1); end
  endtask

  task automatic test_flush3();
    logic [31:0] exp_e [5];
    logic        exp_f [5];
    exp_e = '{32'hd, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_f = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drain();
    mem_valid = 1; exc_in = 32'h400; pc_in = 32'h100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 2) begin exc_in = 32'h100; pc_in = 32'h104; end
      else mem_valid = 0;
      checks++; if (e3 !== exp_e[i] || f3 !== exp_f[i]) begin errors++; $display("FAIL flush3_c%0d got %h/%b exp %h/%b", i, e3, f3, exp_e[i], exp_f[i]); end
      if (i == 1) begin
        checks++; if (k3 !== 1'b1 || p3 !== 32'h20) begin errors++; $display("FAIL flush3_hold got %b/%h exp 1/20", k3, p3); end
      end
    end
    checks++; if (a3 !== 32'h100) begin errors++; $display("FAIL flush3_pc got %h exp 100", a3); end
  endtask

  task automatic test_reset_mid_flush();
    drain();
    mem_valid = 1; exc_in = 32'h100; pc_in = 32'h200;
    cyc();
    mem_valid = 0; rst = 1;
    cyc();
    checks++; if (f3 !== 1'b0 || p3 !== 32'h0 || e3 !== 32'h0) begin errors++; $display("FAIL rstflush got %b/%h/%h exp 0/0/0", f3, p3, e3); end
    checks++; if (k3 !== 1'b0) begin errors++; $display("FAIL rstflush_idle got %b exp 0", k3); end
    rst = 0;
    mem_valid = 1; pc_in = 32'h44;
    cyc();
    checks++; if (e3 !== 32'h8 || a3 !== 32'h44 || f3 !== 1'b1) begin errors++; $display("FAIL rst_resume got %h/%h/%b exp 8/44/1", e3, a3, f3); end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_eret_fwd();
    test_int_priority();
    test_int_masked();
    test_fwd_regs();
    test_multi_flag();
    test_back_to_back();
    test_flush3();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
